arb_grant_hold: RTL and testbench

//  - Sequential stage wrapped around the combinational fixed-priority arbitrator (port 0 highest).
//  - Drives the arbitrator's req input (arb_req_o) and consumes its one-hot grant (arb_gnt_i).
//  - Latches the winner and holds the grant as a locked burst until that requester drops req.
//  - Outputs a registered grant plus its binary index to the downstream mux/datapath.

---
 rtl/arb_pkg.sv | 9 +
 rtl/arb_grant_hold_onehot_to_bin.sv | 13 +
 rtl/arb_grant_hold.sv | 89 ++++++++
 tb/tb_arb_grant_hold.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types, defaults and helpers for the grant-hold stage.
package arb_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int IDX_W = $clog2(NUM_PORTS_DEF);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_e;
  function automatic logic is_onehot(input logic [31:0] v);
    return v != '0 && (v & (v - 32'd1)) == '0;
  endfunction
endpackage

// File: rtl/arb_grant_hold_onehot_to_bin.sv
// onehot_to_bin: binary index of a one-hot vector, 0 when the vector is zero.
module onehot_to_bin import arb_pkg::*; #(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  localparam int IW = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] onehot_i,
  output logic [IW-1:0]        idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) idx_o = onehot_i[i] ? idx_o | IW'(i) : idx_o;
  end
endmodule

// File: rtl/arb_grant_hold.sv
// arb_grant_hold: latches a fixed-priority arbitrator's grant and holds it as a burst.
// Define ARB_HOLD_TIMEOUT_EN to force release after MAX_HOLD cycles and mask the owner.
module arb_grant_hold import arb_pkg::*; #(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int MAX_HOLD = 8,
  localparam int IW = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] arb_req_o,
  input  logic [NUM_PORTS-1:0] arb_gnt_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IW-1:0]        gnt_idx_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 err_o
);
  if (NUM_PORTS < 2 || MAX_HOLD < 2) begin : g_bad_params
    $error("arb_grant_hold: NUM_PORTS and MAX_HOLD must both be >= 2");
  end
  state_e state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d, mask_q;
  logic timeout_q, timeout_d, err_q, err_d;
  logic owner_req, valid, expire;
  assign arb_req_o = req_i & ~mask_q;
  assign owner_req = |(req_i & gnt_q);
  assign valid = is_onehot(32'(arb_gnt_i)) && |(arb_gnt_i & arb_req_o);
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] mask_d;
  assign expire = owner_req && cnt_q == CW'(MAX_HOLD - 1);
  always_comb begin
    cnt_d = (state_q != HOLD && valid) ? '0 :
            (state_q == HOLD && cnt_q != CW'(MAX_HOLD)) ? cnt_q + 1'b1 : cnt_q;
    mask_d = (mask_q & req_i) | ((state_q == HOLD && expire) ? gnt_q : '0);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      mask_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      mask_q <= mask_d;
    end
  end
`else
  assign expire = 1'b0;
  assign mask_q = '0;
`endif
  // The RELEASE cycle is the bubble; arbitration during it lands the next grant right after.
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    timeout_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      HOLD: begin
        state_d = (!owner_req || expire) ? RELEASE : HOLD;
        gnt_d = (!owner_req || expire) ? '0 : gnt_q;
        timeout_d = expire;
      end
      default: begin
        state_d = valid ? HOLD : IDLE;
        gnt_d = valid ? arb_gnt_i : '0;
        err_d = !valid && |arb_gnt_i;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q <= '0;
      timeout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      timeout_q <= timeout_d;
      err_q <= err_d;
    end
  end
  onehot_to_bin #(.NUM_PORTS(NUM_PORTS)) u_idx (.onehot_i(gnt_q), .idx_o(gnt_idx_o));
  assign gnt_o = gnt_q;
  assign busy_o = state_q == HOLD;
  assign timeout_o = timeout_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_arb_grant_hold.sv
// tb_arb_grant_hold: directed checks of arb_grant_hold fed by a fixed-priority arbitrator.
module tb_arb_grant_hold;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, arb_req, arb_gnt, gnt, force_gnt = '0, prio_gnt;
  logic force_en = 1'b0;
  logic [1:0] idx;
  logic busy, tmo, err;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign prio_gnt = arb_req & (~arb_req + 4'd1);
  assign arb_gnt = force_en ? force_gnt : prio_gnt;
  arb_grant_hold #(.NUM_PORTS(4), .MAX_HOLD(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .arb_req_o(arb_req), .arb_gnt_i(arb_gnt),
    .gnt_o(gnt), .gnt_idx_o(idx), .busy_o(busy), .timeout_o(tmo), .err_o(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(tmo), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    req = 4'b1010;
    step();
    chk("t2_gnt_c1", 32'(gnt), 32'b0010);
    chk("t2_idx_c1", 32'(idx), 1);
    chk("t2_busy_c1", 32'(busy), 1);
    step();
    chk("t2_gnt_c2", 32'(gnt), 32'b0010);
    step();
    chk("t2_gnt_c3", 32'(gnt), 32'b0010);
    req = 4'b1000;
    step();
    chk("t2_bubble_gnt", 32'(gnt), 0);
    chk("t2_bubble_busy", 32'(busy), 0);
    step();
    chk("t2_next_gnt", 32'(gnt), 32'b1000);
    chk("t2_next_idx", 32'(idx), 3);
    req = 4'b0000;
    step();
    step();
    req = 4'b0100;
    step();
    chk("t3_gnt", 32'(gnt), 32'b0100);
    chk("t3_idx", 32'(idx), 2);
    req = 4'b0111;
    step();
    chk("t3_hold1", 32'(gnt), 32'b0100);
    step();
    chk("t3_hold2", 32'(gnt), 32'b0100);
    req = 4'b0011;
    step();
    chk("t3_bubble", 32'(gnt), 0);
    step();
    chk("t3_p0_gnt", 32'(gnt), 32'b0001);
    chk("t3_p0_idx", 32'(idx), 0);
    req = 4'b0000;
    step();
    step();
    req = 4'b0100;
    step();
    chk("t1_pre_gnt", 32'(gnt), 32'b0100);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_gnt", 32'(gnt), 0);
    chk("t1_async_busy", 32'(busy), 0);
    chk("t1_async_idx", 32'(idx), 0);
    step();
    rst = 1'b0;
    req = 4'b0011;
    force_en = 1'b1;
    force_gnt = 4'b0011;
    step();
    chk("t4_multi_err", 32'(err), 1);
    chk("t4_multi_gnt", 32'(gnt), 0);
    force_gnt = 4'b0000;
    step();
    chk("t4_err_pulse", 32'(err), 0);
    chk("t4_still_idle", 32'(busy), 0);
    req = 4'b0001;
    force_gnt = 4'b0100;
    step();
    chk("t4_noreq_err", 32'(err), 1);
    chk("t4_noreq_gnt", 32'(gnt), 0);
    force_en = 1'b0;
    step();
    chk("t4_hold_gnt", 32'(gnt), 32'b0001);
    chk("t4_err_clr", 32'(err), 0);
    force_en = 1'b1;
    force_gnt = 4'b0011;
    step();
    chk("t4_hold_ign_err", 32'(err), 0);
    chk("t4_hold_ign_gnt", 32'(gnt), 32'b0001);
    force_en = 1'b0;
    req = 4'b0000;
    step();
    step();
    req = 4'b0011;
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_burst_gnt", 32'(gnt), 32'b0001);
      chk("t5_burst_tmo", 32'(tmo), 0);
    end
    step();
    chk("t5_tmo_pulse", 32'(tmo), 1);
    chk("t5_tmo_gnt", 32'(gnt), 0);
    chk("t5_mask", 32'(arb_req), 32'b0010);
    step();
    chk("t5_next_gnt", 32'(gnt), 32'b0010);
    chk("t5_tmo_clr", 32'(tmo), 0);
    chk("t5_still_mask", 32'(arb_req), 32'b0010);
    req = 4'b0010;
    step();
    req = 4'b0011;
    #1;
    chk("t5_unmask", 32'(arb_req), 32'b0011);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_gnt", 32'(gnt), 32'b0001);
      chk("t6_tmo", 32'(tmo), 0);
      chk("t6_arb_req", 32'(arb_req), 32'b0011);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
